// File: rtl/regfile.sv
// regfile: NUM_REGS x DATA_W register file with r0 hardwired to zero, one write port and two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              wr_en;
  logic              hit1;
  logic              hit2;
  always_comb begin
    wr_en = we && (waddr != '0);
    for (int i = 0; i < NUM_REGS; i++)
      mem_d[i] = (i == 0) ? '0 : (wr_en && waddr == ADDR_W'(i)) ? wdata : mem_q[i];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++)
      mem_q[i] <= rst ? '0 : mem_d[i];
  end
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    hit1 = wr_en && raddr1 == waddr;
    hit2 = wr_en && raddr2 == waddr;
  end
`else
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
  end
`endif
  always_comb begin
    rdata1 = (rst || !re1 || raddr1 == '0) ? '0 : hit1 ? wdata : mem_q[raddr1];
    rdata2 = (rst || !re2 || raddr2 == '0) ? '0 : hit2 ? wdata : mem_q[raddr2];
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomized checks of regfile against an array model.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [32];

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) model[i] = '0;

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) model[i] <= '0;
    else if (we && waddr != 0) model[waddr] <= wdata;
  end

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr != 0 && ra == waddr) return wdata;
`endif
    return model[ra];
  endfunction

  always @(negedge clk) begin
    logic [31:0] e1;
    logic [31:0] e2;
    e1 = exp_rd(re1, raddr1);
    e2 = exp_rd(re2, raddr2);
    vectors += 2;
    if (rdata1 !== e1) begin
      miscompares++;
      $display("FAIL model_rd1 t=%0t addr=%0d: got %h want %h", $time, raddr1, rdata1, e1);
    end
    if (rdata2 !== e2) begin
      miscompares++;
      $display("FAIL model_rd2 t=%0t addr=%0d: got %h want %h", $time, raddr2, rdata2, e2);
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #2;
  endtask

  initial begin
    logic [4:0] wa;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5, 1, 5);
    lit("rst_rd1", rdata1, 32'h0);
    lit("rst_rd2", rdata2, 32'h0);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0, 0);
    lit("r5_written", rdata1, 32'hDEADBEEF);
    step(1, 0, 0, 0, 1, 5, 1, 5);
    lit("rst_hold_rd1", rdata1, 32'h0);
    lit("rst_hold_rd2", rdata2, 32'h0);
    step(0, 0, 0, 0, 1, 5, 0, 0);
    lit("r5_cleared", rdata1, 32'h0);
    step(0, 1, 3, 32'h00001234, 0, 0, 0, 0);
    step(0, 1, 31, 32'hFFFFFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 1, 31);
    lit("dual_r3", rdata1, 32'h00001234);
    lit("dual_r31", rdata2, 32'hFFFFFFFF);
    step(0, 1, 0, 32'hA5A5A5A5, 1, 0, 1, 0);
    lit("r0_same_rd1", rdata1, 32'h0);
    lit("r0_same_rd2", rdata2, 32'h0);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    lit("r0_next_rd1", rdata1, 32'h0);
    lit("r0_next_rd2", rdata2, 32'h0);
    step(0, 1, 7, 32'h11111111, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 7, 0, 0);
    lit("re1_off", rdata1, 32'h0);
    re1 = 1'b1;
    #1;
    lit("re1_on", rdata1, 32'h11111111);
    step(0, 1, 9, 32'h0000AAAA, 0, 0, 0, 0);
    step(0, 1, 9, 32'h0000BBBB, 0, 0, 1, 9);
`ifdef REGFILE_BYPASS_EN
    lit("hazard_same", rdata2, 32'h0000BBBB);
`else
    lit("hazard_same", rdata2, 32'h0000AAAA);
`endif
    step(0, 0, 0, 0, 0, 0, 1, 9);
    lit("hazard_next", rdata2, 32'h0000BBBB);
    step(0, 1, 4, 32'hCAFEF00D, 0, 0, 0, 0);
    step(1, 1, 4, 32'h12345678, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 1, 4);
    lit("rst_race_rd1", rdata1, 32'h0);
    lit("rst_race_rd2", rdata2, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      wa = 5'($urandom_range(0, 31));
      step($urandom_range(0, 63) == 0, 1'($urandom), wa, $urandom,
           $urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
    end
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file for the stage-1 MIPS pipeline.
- Services the two operand-read requests issued by the decode stage (read enable plus 5-bit address per port) and returns data in the same cycle.
- Accepts one writeback per clock from the write-back path.
- Register 0 is hardwired to zero. An optional same-cycle write-to-read bypass covers the write-back/decode hazard.

Parameters:
- DATA_W, 32, register width in bits; matches the decode stage's operand buses.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- we  input  1  write enable from write-back.
- waddr  input  ADDR_W  destination register of the write.
- wdata  input  DATA_W  write data.
- re1  input  1  read enable, port 1; driven by the decode stage's reg1 read request.
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1; feeds the decode stage's reg1 data input.
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2.

Behaviour:
Storage
- Array of NUM_REGS x DATA_W flops; entry 0 is never written and always reads as 0.

Reset
- On a rising edge with rst=1, all entries are cleared to 0 and any concurrent write is discarded.
- While rst=1, rdata1 = rdata2 = 0, combinationally.
- Reset asserted while a write is in flight (we=1 on the same edge): the write is lost and the target entry ends up 0.

Write
- On a rising edge with rst=0, we=1 and waddr!=0: mem[waddr] <= wdata.
- we=1 with waddr=0 is silently ignored.
- Write latency is one cycle: the value is visible to a non-bypassed read from the following cycle.

Read (per port n = 1, 2; purely combinational, zero-cycle latency)
- Priority, highest first:
  1. rst=1 -> 0
  2. ren=0 -> 0
  3. raddrn=0 -> 0
  4. bypass hit (see Optional Feature) -> wdata
  5. otherwise -> mem[raddrn]
- Both ports are independent. Both may read the same address; both see identical data.
- No X propagation: any undriven or unwritten entry reads 0 after reset.

Simultaneous events
- Write and read of different addresses in the same cycle: the read returns the stored value and the write commits at the edge.
- Write and read of the same nonzero address in the same cycle: result depends on the bypass feature (below).

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: if rst=0, we=1, waddr!=0, ren=1 and raddrn==waddr, then rdatan = wdata in the same cycle (write-through forwarding). This removes the 1-cycle write-back/decode hazard.
- Not defined: such a read returns the old mem[raddrn]. The new value appears from the next cycle. Hazard avoidance is left to pipeline control.
- Register-0 and reset rules are unchanged in both builds.

Test Plan:
1. Reset clear: write 0xDEADBEEF to r5, then assert rst for one edge, then read r5 with re1=1 -> rdata1=0. While rst=1, rdata1=rdata2=0 regardless of re/addr.
2. Write/readback, dual port: write r3=0x00001234 and r31=0xFFFFFFFF on consecutive cycles. Next cycle re1=re2=1, raddr1=3, raddr2=31 -> rdata1=0x00001234, rdata2=0xFFFFFFFF.
3. r0 immunity: we=1, waddr=0, wdata=0xA5A5A5A5. Next cycle read r0 on both ports -> 0, including same-cycle with REGFILE_BYPASS_EN defined.
4. Read enable gating: r7=0x11111111 stored; re1=0, raddr1=7 -> rdata1=0. Set re1=1 -> rdata1=0x11111111 in the same cycle.
5. Same-cycle hazard: r9=0x0000AAAA stored; drive we=1, waddr=9, wdata=0x0000BBBB and re2=1, raddr2=9 -> rdata2=0x0000BBBB with REGFILE_BYPASS_EN, 0x0000AAAA without. Next cycle rdata2=0x0000BBBB in both builds.
6. Reset racing a write: rst=1 and we=1, waddr=4, wdata=0x12345678 on the same edge. Deassert rst, read r4 -> 0.
